// File: rtl/branch_outcome_checker.sv
// -----------------------------------------------------------------------------
// branch_outcome_checker
//
// Producer side of the prediction-accuracy statistics path. Predictions made
// at fetch (PC + predicted direction) are queued in an in-order FIFO. Each
// resolved outcome from execute is matched against the FIFO head. One cycle
// later the block emits a single-cycle `enable` pulse, with `BranchResult` = 1
// when the prediction was correct. A resolved PC that does not match the head
// is not counted and raises the sticky `mismatch_err` flag instead.
//
// Ports
//   Clk           in   clock, all logic on the rising edge
//   reset         in   synchronous, active-low reset
//   flush         in   discard all outstanding predictions
//   pred_valid    in   prediction offered
//   pred_pc       in   PC of the predicted branch      [PC_WIDTH]
//   pred_taken    in   predicted direction
//   pred_ready    out  FIFO can accept a prediction
//   res_valid     in   resolved outcome offered
//   res_pc        in   PC of the resolved branch       [PC_WIDTH]
//   res_taken     in   actual direction
//   res_ready     out  an outcome can be consumed
//   BranchResult  out  1 = prediction correct (qualified by enable)
//   enable        out  one-cycle pulse, one branch to count
//   mismatch_err  out  sticky ordering-corruption flag
//   occupancy     out  number of queued predictions    [PTR_W+1]
// -----------------------------------------------------------------------------
module branch_outcome_checker #(
  parameter int DEPTH    = 8,
  parameter int PTR_W    = 3,
  parameter int PC_WIDTH = 32
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                pred_valid,
  input  logic [PC_WIDTH-1:0] pred_pc,
  input  logic                pred_taken,
  output logic                pred_ready,
  input  logic                res_valid,
  input  logic [PC_WIDTH-1:0] res_pc,
  input  logic                res_taken,
  output logic                res_ready,
  output logic                BranchResult,
  output logic                enable,
  output logic                mismatch_err,
  output logic [PTR_W:0]      occupancy
);

  localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

  // FIFO storage (no reset: contents only observable through the pop path)
  logic [PC_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic                r_taken_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;

  logic r_enable;
  logic r_result;
  logic r_mismatch;

  logic [PTR_W:0]      w_occupancy;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [PC_WIDTH-1:0] w_head_pc;
  logic                w_head_taken;
  logic                w_pc_match;

  logic [PTR_W:0] w_wr_ptr_nxt;
  logic [PTR_W:0] w_rd_ptr_nxt;
  logic           w_enable_nxt;
  logic           w_result_nxt;
  logic           w_mismatch_nxt;

  // Occupancy and full/empty status derived from the registered pointers
  always_comb begin
    w_occupancy = r_wr_ptr - r_rd_ptr;
    w_empty     = (r_wr_ptr == r_rd_ptr);
    // Full: same slot index, opposite wrap bit
    w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                  (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  end

  assign pred_ready = ~w_full;
  assign res_ready  = ~w_empty;
  assign occupancy  = w_occupancy;

  // Handshakes; reset and flush both suppress any transfer in their cycle
  always_comb begin
    w_push = pred_valid & ~w_full  & reset & ~flush;
    w_pop  = res_valid  & ~w_empty & reset & ~flush;
  end

  // Head-of-queue read and PC comparison
  always_comb begin
    w_head_pc    = r_pc_mem[r_rd_ptr[PTR_W-1:0]];
    w_head_taken = r_taken_mem[r_rd_ptr[PTR_W-1:0]];
    w_pc_match   = (res_pc == w_head_pc);
  end

  // Next-state computation: reset > flush > push/pop
  always_comb begin
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_enable_nxt   = 1'b0;
    w_result_nxt   = r_result;
    w_mismatch_nxt = r_mismatch;

    if (!reset) begin
      w_wr_ptr_nxt   = PTR_ZERO;
      w_rd_ptr_nxt   = PTR_ZERO;
      w_enable_nxt   = 1'b0;
      w_result_nxt   = 1'b0;
      w_mismatch_nxt = 1'b0;
    end else if (flush) begin
      // BranchResult and mismatch_err hold; only the queue is discarded
      w_wr_ptr_nxt = PTR_ZERO;
      w_rd_ptr_nxt = PTR_ZERO;
      w_enable_nxt = 1'b0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end

      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        if (w_pc_match) begin
          w_enable_nxt = 1'b1;
          w_result_nxt = (res_taken == w_head_taken);
        end else begin
          // Ordering corruption: branch is not counted
          w_enable_nxt   = 1'b0;
          w_result_nxt   = 1'b0;
          w_mismatch_nxt = 1'b1;
        end
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_enable_nxt = 1'b0;
      end
    end
  end

  // Pointer and output registers (reset folded into the next-state logic)
  always_ff @(posedge Clk) begin
    r_wr_ptr   <= w_wr_ptr_nxt;
    r_rd_ptr   <= w_rd_ptr_nxt;
    r_enable   <= w_enable_nxt;
    r_result   <= w_result_nxt;
    r_mismatch <= w_mismatch_nxt;
  end

  // FIFO storage write on push
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr[PTR_W-1:0]]    <= pred_pc;
      r_taken_mem[r_wr_ptr[PTR_W-1:0]] <= pred_taken;
    end
  end

  assign enable       = r_enable;
  assign BranchResult = r_result;
  assign mismatch_err = r_mismatch;

endmodule

// File: tb/tb_branch_outcome_checker.sv
// -----------------------------------------------------------------------------
// Testbench for branch_outcome_checker. A queue-based reference model tracks
// outstanding predictions and the expected registered outputs; directed steps
// cover the documented scenarios, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_branch_outcome_checker;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int PCW   = 32;

  logic           Clk;
  logic           reset;
  logic           flush;
  logic           pred_valid;
  logic [PCW-1:0] pred_pc;
  logic           pred_taken;
  logic           pred_ready;
  logic           res_valid;
  logic [PCW-1:0] res_pc;
  logic           res_taken;
  logic           res_ready;
  logic           BranchResult;
  logic           enable;
  logic           mismatch_err;
  logic [PTR_W:0] occupancy;

  branch_outcome_checker #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_WIDTH(PCW)) dut (
    .Clk(Clk), .reset(reset), .flush(flush),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_ready(res_ready),
    .BranchResult(BranchResult), .enable(enable),
    .mismatch_err(mismatch_err), .occupancy(occupancy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [PCW-1:0] pc;
    logic           taken;
  } ent_t;

  ent_t q[$];
  logic m_en;
  logic m_res;
  logic m_mm;

  int checks = 0;
  int errors = 0;
  int dut_correct = 0;
  int dut_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PCW-1:0] head_pc();
    if (q.size() != 0) return q[0].pc;
    else return 32'hDEAD_BEEF;
  endfunction

  function automatic logic head_taken();
    if (q.size() != 0) return q[0].taken;
    else return 1'b0;
  endfunction

  // One clock cycle: drive inputs, check readies, update model, check outputs.
  task automatic step(input logic pv, input logic [PCW-1:0] ppc, input logic pt,
                      input logic rv, input logic [PCW-1:0] rpc, input logic rt,
                      input logic fl, input logic rs, input string tag);
    logic do_push;
    logic do_pop;
    ent_t h;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt;
    res_valid  = rv; res_pc  = rpc; res_taken  = rt;
    flush = fl; reset = rs;
    #1;
    check({tag, ".pred_ready"}, 64'(pred_ready), 64'(q.size() != DEPTH));
    check({tag, ".res_ready"},  64'(res_ready),  64'(q.size() != 0));

    if (!rs) begin
      q.delete();
      m_en = 1'b0; m_res = 1'b0; m_mm = 1'b0;
    end else if (fl) begin
      q.delete();
      m_en = 1'b0;
    end else begin
      do_push = pv && (q.size() != DEPTH);
      do_pop  = rv && (q.size() != 0);
      m_en = 1'b0;
      if (do_pop) begin
        h = q.pop_front();
        if (h.pc == rpc) begin
          m_en  = 1'b1;
          m_res = (h.taken == rt);
        end else begin
          m_res = 1'b0;
          m_mm  = 1'b1;
        end
      end
      if (do_push) q.push_back('{pc: ppc, taken: pt});
    end

    @(posedge Clk);
    #1;
    check({tag, ".enable"},       64'(enable),       64'(m_en));
    check({tag, ".BranchResult"}, 64'(BranchResult), 64'(m_res));
    check({tag, ".mismatch_err"}, 64'(mismatch_err), 64'(m_mm));
    check({tag, ".occupancy"},    64'(occupancy),    64'(q.size()));
    if (enable === 1'b1) begin
      dut_total++;
      if (BranchResult === 1'b1) dut_correct++;
    end
  endtask

  task automatic push(input logic [PCW-1:0] pc, input logic t, input string tag);
    step(1'b1, pc, t, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic resolve(input logic [PCW-1:0] pc, input logic t, input string tag);
    step(1'b0, 32'h0, 1'b0, 1'b1, pc, t, 1'b0, 1'b1, tag);
  endtask

  initial begin
    logic [PCW-1:0] pc;
    logic           pv, rv, fl, rs, t, rt;

    // Reset with no model expectations on the undefined pre-reset state
    pred_valid = 1'b0; pred_pc = 32'h0; pred_taken = 1'b0;
    res_valid = 1'b0; res_pc = 32'h0; res_taken = 1'b0;
    flush = 1'b0; reset = 1'b0;
    q.delete(); m_en = 1'b0; m_res = 1'b0; m_mm = 1'b0;
    @(posedge Clk); #1;
    check("reset.occupancy",    64'(occupancy),    64'd0);
    check("reset.enable",       64'(enable),       64'd0);
    check("reset.BranchResult", 64'(BranchResult), 64'd0);
    check("reset.mismatch_err", 64'(mismatch_err), 64'd0);
    check("reset.pred_ready",   64'(pred_ready),   64'd1);
    check("reset.res_ready",    64'(res_ready),    64'd0);

    // Basic match
    push(32'h0000_1000, 1'b1, "basic_push");
    check("basic.occ1", 64'(occupancy), 64'd1);
    resolve(32'h0000_1000, 1'b1, "basic_res");
    check("basic.en", 64'(enable), 64'd1);
    check("basic.br", 64'(BranchResult), 64'd1);

    // Mispredict, with a downstream counter pair observed from the outputs
    dut_correct = 0; dut_total = 0;
    push(32'h0000_2000, 1'b0, "mispred_push");
    resolve(32'h0000_2000, 1'b1, "mispred_res");
    check("mispred.correct", 64'(dut_correct), 64'd0);
    check("mispred.total",   64'(dut_total),   64'd1);

    // Full and wrap-around
    for (int i = 1; i <= 8; i++) push(32'(i * 16), 1'(i), "fill");
    check("full.occ", 64'(occupancy), 64'd8);
    check("full.pred_ready", 64'(pred_ready), 64'd0);
    push(32'h0000_0090, 1'b1, "refused");
    dut_correct = 0; dut_total = 0;
    for (int i = 1; i <= 8; i++) resolve(32'(i * 16), 1'(i), "drain");
    check("drain.correct", 64'(dut_correct), 64'd8);
    for (int i = 0; i < 4; i++) push(32'h0000_0A00 + 32'(i * 4), 1'(i), "wrap_push");
    for (int i = 0; i < 4; i++) resolve(32'h0000_0A00 + 32'(i * 4), 1'(i), "wrap_res");

    // Simultaneous push/pop at occupancy 3
    for (int i = 0; i < 3; i++) push(32'h0000_3000 + 32'(i * 4), 1'b1, "sim_fill");
    step(1'b1, 32'h0000_300C, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b1, "sim_pp");
    check("sim.occ3", 64'(occupancy), 64'd3);
    check("sim.en", 64'(enable), 64'd1);
    for (int i = 0; i < 3; i++) resolve(head_pc(), head_taken(), "sim_drain");
    // Empty: resolve is not accepted in the same cycle as the push
    step(1'b1, 32'h0000_4000, 1'b1, 1'b1, 32'h0000_4000, 1'b1, 1'b0, 1'b1, "empty_pp");
    check("empty.en", 64'(enable), 64'd0);
    check("empty.occ1", 64'(occupancy), 64'd1);
    resolve(32'h0000_4000, 1'b1, "empty_res");

    // PC mismatch, sticky across flush, cleared by reset
    push(32'h0000_0100, 1'b1, "mm_push");
    resolve(32'h0000_0104, 1'b1, "mm_res");
    check("mm.en", 64'(enable), 64'd0);
    check("mm.flag", 64'(mismatch_err), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, "mm_flush");
    check("mm.after_flush", 64'(mismatch_err), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "mm_reset");
    check("mm.after_reset", 64'(mismatch_err), 64'd0);

    // Flush mid-stream together with push and pop
    for (int i = 0; i < 5; i++) push(32'h0000_5000 + 32'(i * 4), 1'b0, "fl_fill");
    step(1'b1, 32'h0000_5100, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 1'b1, 1'b1, "fl_pp");
    check("flush.occ", 64'(occupancy), 64'd0);
    check("flush.en", 64'(enable), 64'd0);

    // Reset during a pop handshake
    for (int i = 0; i < 3; i++) push(32'h0000_6000 + 32'(i * 4), 1'b1, "rs_fill");
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_6000, 1'b1, 1'b0, 1'b0, "rs_pop");
    check("rst.occ", 64'(occupancy), 64'd0);
    check("rst.en", 64'(enable), 64'd0);
    check("rst.br", 64'(BranchResult), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pv = 1'($urandom_range(0, 99) < 60);
      rv = 1'($urandom_range(0, 99) < 55);
      fl = 1'($urandom_range(0, 99) < 3);
      rs = 1'($urandom_range(0, 99) >= 2);
      t  = 1'($urandom);
      rt = 1'($urandom);
      pc = {$urandom} & 32'hFFFF_FFFC;
      if (q.size() != 0 && $urandom_range(0, 99) < 93)
        step(pv, pc, t, rv, head_pc(), rt, fl, rs, "rand");
      else
        step(pv, pc, t, rv, {$urandom}, rt, fl, rs, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_outcome_checker.md
Name: branch_outcome_checker

Overview:
- Producer side of the prediction-accuracy statistics path.
- Queues each prediction issued by the predictor at fetch (PC plus predicted direction) in an in-order FIFO.
- Matches the prediction, in order, against the resolved outcome from execute, then emits a one-cycle `enable` pulse with `BranchResult` (1 = correctly predicted). Both feed the statistics counter directly.
- Also flags ordering corruption (PC mismatch) and supports pipeline flush.

Parameters:
- DEPTH, 8, number of outstanding predictions; power of two, ≥2.
- PTR_W, 3, log2(DEPTH).
- PC_WIDTH, 32, branch PC width.

Ports:
- Clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- flush  input  1  discard all outstanding predictions.
- pred_valid  input  1  prediction offered.
- pred_pc  input  PC_WIDTH  PC of the predicted branch.
- pred_taken  input  1  predicted direction.
- pred_ready  output  1  FIFO can accept a prediction.
- res_valid  input  1  resolved outcome offered.
- res_pc  input  PC_WIDTH  PC of the resolved branch.
- res_taken  input  1  actual direction.
- res_ready  output  1  outcome can be consumed.
- BranchResult  output  1  1 = prediction matched outcome; valid only when enable = 1.
- enable  output  1  one-cycle pulse: one branch to be counted.
- mismatch_err  output  1  sticky: a resolved PC did not match the FIFO head.
- occupancy  output  PTR_W+1  number of queued predictions.

Behaviour:
- **Reset.** reset = 0 at a rising Clk clears, at that edge:
  - write and read pointers, so occupancy = 0;
  - BranchResult = 0, enable = 0, mismatch_err = 0.
  - Reset mid-operation drops every queued entry. Any pulse that would have issued the following cycle is suppressed.
- **Ready signals.** Both are combinational from registered occupancy.
  - pred_ready = (occupancy != DEPTH).
  - res_ready = (occupancy != 0).
- **Push.** pred_valid & pred_ready stores {pred_pc, pred_taken} at the write pointer. The write pointer wraps modulo DEPTH.
- **Pop.** res_valid & res_ready reads the head entry and advances the read pointer modulo DEPTH.
- **Registered outputs, one cycle after a pop handshake:**
  - If res_pc == head PC: enable = 1 and BranchResult = (res_taken == head taken).
  - If res_pc != head PC: enable = 0 (branch not counted), BranchResult = 0, mismatch_err set to 1. mismatch_err holds until reset; flush does not clear it.
  - With no pop, enable = 0 and BranchResult holds its last value.
- **Latency.** Exactly 1 cycle from pop handshake to enable. Sustained throughput is one pop per cycle, so enable can be high on consecutive cycles.
- **Simultaneous push and pop.** Both occur; occupancy is unchanged.
  - When full, pred_ready = 0, so no push occurs even if a pop happens that cycle.
  - When empty, res_ready = 0, so a prediction pushed this cycle cannot be resolved in the same cycle.
- **Occupancy.** occupancy = occupancy + push − pop, never outside 0..DEPTH. Full and empty are distinguished by the extra pointer bit.
- **Flush.** flush = 1 (with reset = 1) at an edge:
  - pointers cleared, occupancy = 0;
  - any push or pop that cycle is ignored and no enable pulse results;
  - an enable pulse already registered from the prior cycle still appears.
- **Priority.** reset > flush > push/pop.
- **Storage.** FIFO storage needs no reset. Contents are not visible except through the pop path.

Test Plan:
- **Basic match.** After reset, push {0x0000_1000, taken=1}; then resolve {0x0000_1000, taken=1} → next cycle enable = 1, BranchResult = 1; occupancy 1→0; mismatch_err = 0.
- **Mispredict.** Push {0x2000, taken=0}; resolve {0x2000, taken=1} → enable = 1, BranchResult = 0. A downstream counter pair must read Correct = 0, Total = 1.
- **Full and wrap-around.**
  - Push 8 predictions PCs 0x10..0x80 → occupancy = 8, pred_ready = 0; a 9th pred_valid is refused.
  - Resolve all 8 in order with outcomes matching → 8 consecutive enable pulses, all BranchResult = 1.
  - Push 4 more → entries wrap correctly and resolve in order.
- **Simultaneous push/pop at occupancy 3.** Occupancy stays 3 and one enable pulse appears. At occupancy 0 with res_valid = 1 and a push in the same cycle: res_ready = 0, no pulse, occupancy → 1.
- **PC mismatch.** Queue 0x100, resolve with 0x104 → enable stays 0 and mismatch_err = 1 (sticky). Flush leaves it at 1; reset low for one cycle clears it.
- **Flush and reset mid-stream.** With occupancy 5, assert flush together with push and pop → occupancy = 0 and no enable the following cycle. Refill to 3, then pull reset low while a pop handshakes → occupancy 0, enable 0, BranchResult 0 on the next cycle.
